// File: rtl/cpu_sequencer.sv
// cpu_sequencer: sequential control core behind the microcode decoder.
// Holds micro-step, instruction register, PC, flags and interrupt state, and takes IRQs at instruction boundaries.
module cpu_sequencer #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] IRQ_VECTOR = 16'h0004
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] D,
    input  logic [4:0]  ALUFlags,
    input  logic        CounterRST,
    input  logic        PCW,
    input  logic        PCWriteFromD,
    input  logic        DToInstr,
    input  logic        wFlags,
    input  logic        enableInterrupts,
    input  logic        IRQ,
    output logic [3:0]  Counter,
    output logic [15:0] Instr,
    output logic [4:0]  Flags,
    output logic [15:0] PC,
    output logic [15:0] EPC,
    output logic        IE,
    output logic        IrqAck
);

    logic [3:0]  counter_q, counter_d;
    logic [15:0] instr_q, instr_d;
    logic [4:0]  flags_q, flags_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] epc_q, epc_d;
    logic        ie_q, ie_d;
    logic        irq_ack_q, irq_ack_d;
    logic        branch_pend_q, branch_pend_d;
    logic [15:0] pc_seq_s;
    logic        take_irq_s;

    // Sequential PC (rules without interrupt) and the branch-pending bookkeeping
    always_comb begin
        pc_seq_s      = pc_q;
        branch_pend_d = branch_pend_q;
        if (PCWriteFromD) begin
            pc_seq_s      = D;
            branch_pend_d = 1'b1;
        end else if (PCW && branch_pend_q) begin
            pc_seq_s      = pc_q;
            branch_pend_d = 1'b0;
        end else if (PCW) begin
            pc_seq_s      = pc_q + 16'd1;
            branch_pend_d = branch_pend_q;
        end else begin
            pc_seq_s      = pc_q;
            branch_pend_d = branch_pend_q;
        end
        if (CounterRST) begin
            branch_pend_d = 1'b0;
        end else begin
            branch_pend_d = branch_pend_d;
        end
    end

    assign take_irq_s = CounterRST & ie_q & IRQ;

    // Next-state for counter, registers and interrupt entry
    always_comb begin
        counter_d = counter_q;
        instr_d   = instr_q;
        flags_d   = flags_q;
        pc_d      = pc_seq_s;
        epc_d     = epc_q;
        ie_d      = ie_q;
        irq_ack_d = 1'b0;

        if (CounterRST) begin
            counter_d = 4'd0;
        end else begin
            counter_d = counter_q + 4'd1;
        end

        if (DToInstr) begin
            instr_d = D;
        end else begin
            instr_d = instr_q;
        end

        if (wFlags) begin
            flags_d = ALUFlags;
        end else begin
            flags_d = flags_q;
        end

        // Interrupt entry wins over enableInterrupts; EPC keeps the would-be PC
        if (take_irq_s) begin
            pc_d      = IRQ_VECTOR;
            epc_d     = pc_seq_s;
            ie_d      = 1'b0;
            irq_ack_d = 1'b1;
        end else if (enableInterrupts) begin
            ie_d = 1'b1;
        end else begin
            ie_d = ie_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            counter_q     <= 4'd0;
            instr_q       <= 16'd0;
            flags_q       <= 5'd0;
            pc_q          <= RESET_PC;
            epc_q         <= 16'd0;
            ie_q          <= 1'b0;
            irq_ack_q     <= 1'b0;
            branch_pend_q <= 1'b0;
        end else begin
            counter_q     <= counter_d;
            instr_q       <= instr_d;
            flags_q       <= flags_d;
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            ie_q          <= ie_d;
            irq_ack_q     <= irq_ack_d;
            branch_pend_q <= branch_pend_d;
        end
    end

    assign Counter = counter_q;
    assign Instr   = instr_q;
    assign Flags   = flags_q;
    assign PC      = pc_q;
    assign EPC     = epc_q;
    assign IE      = ie_q;
    assign IrqAck  = irq_ack_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Sequential control core that drives the combinational microcode decoder. It holds the 4-bit micro-step counter, the 16-bit instruction register, the program counter, the 5-bit flags register and interrupt-enable state. It applies the decoder's strobes (CounterRST, PCW, PCWriteFromD, DToInstr, wFlags, enableInterrupts) on each clock edge. It also takes maskable interrupts at instruction boundaries.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- IRQ_VECTOR, 16'h0004, PC value loaded when an interrupt is taken
- CLK  input  1  system clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- D  input  16  data bus (instruction fetch, branch target)
- ALUFlags  input  5  flag outputs of the ALU
- CounterRST, PCW, PCWriteFromD, DToInstr, wFlags, enableInterrupts  input  1 each  microcode strobes for the current step
- IRQ  input  1  level-sensitive interrupt request
- Counter  output  4  current micro-step, feeds the decoder
- Instr  output  16  instruction register, feeds the decoder
- Flags  output  5  flags register, feeds the decoder
- PC  output  16  program counter, routed to the address bus externally when PCToA
- EPC  output  16  saved return address of the last taken interrupt
- IE  output  1  interrupt enable
- IrqAck  output  1  one-cycle pulse when an interrupt is taken

## Operation
- Reset (RST=1 at an edge) sets the following state; reset overrides all other inputs:
  - Counter=0, Instr=0, Flags=0, PC=RESET_PC, EPC=0
  - IE=0, IrqAck=0, internal BranchPend=0
- Counter:
  - If CounterRST, goes to 0.
  - Otherwise increments by 1, modulo 16; 4'hF wraps to 0 with no other side effect.
- Instr loads D when DToInstr; otherwise it holds.
- Flags loads ALUFlags when wFlags; otherwise it holds.
- PC update, in priority order:
  1. Interrupt taken (see below): PC=IRQ_VECTOR.
  2. PCWriteFromD: PC=D and BranchPend=1.
  3. PCW with BranchPend=1: PC holds and BranchPend=0. The terminal-step increment is suppressed after a taken branch.
  4. PCW: PC=PC+1, modulo 2^16; 16'hFFFF wraps to 0.
  5. Otherwise PC holds.
- BranchPend also clears whenever CounterRST is sampled, whatever path is taken.
- IE is set by enableInterrupts and cleared when an interrupt is taken. Clearing has priority if both occur in the same cycle.
- Interrupt taken when CounterRST=1, IE=1 and IRQ=1 at the same edge:
  - EPC is loaded with the PC value that rules 2–5 would have produced.
  - PC=IRQ_VECTOR, IE=0, Counter=0, IrqAck=1 for the following cycle only.
- Flags and Instr updates in the same cycle still apply.
- IRQ is ignored when IE=0 and at every non-terminal step. It is never latched; the source must hold it until acknowledged.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Fetch sequence:
  - Counter=0: PC valid on the address bus.
  - Counter=1: DToInstr and PCW are sampled at the edge; Instr and PC+1 are visible at Counter=2.
- Step strobes are sampled at the edge ending that step; their effects are visible in the next step.
- Instruction length is set entirely by when CounterRST arrives. A 4-step instruction (steps 0–3, CounterRST at step 4) occupies 5 cycles.
- Interrupt latency: taken at the first instruction boundary with IE=1. The first vector fetch is at Counter=0 in the following cycle.
- IE set at step 2 (return-from-interrupt branch) is already effective at that instruction's terminal step. Back-to-back interrupts are therefore possible.
- A reset asserted mid-instruction abandons it; no partial PC or Flags update from that cycle.

## Test plan
- Reset: RST high one edge with arbitrary strobes -> Counter=0, PC=RESET_PC, Instr=0, Flags=0, IE=0, IrqAck=0.
- Fetch + straight-line instruction:
  - Stimulus: PC=16'h0010, D=16'h1234, DToInstr+PCW at step 1, CounterRST+PCW at step 4.
  - Required: Instr=16'h1234; PC=16'h0011 after fetch, 16'h0012 after terminal step; Counter back to 0.
- Taken branch:
  - Stimulus: PCWriteFromD with D=16'h0200 at step 2, CounterRST+PCW at step 3.
  - Required: PC=16'h0200 at step 3 and still 16'h0200 at next Counter=0 (increment suppressed).
- Interrupt entry:
  - Stimulus: IE=1, IRQ=1 at a terminal step where PC would become 16'h0031.
  - Required: EPC=16'h0031, PC=IRQ_VECTOR, IE=0, IrqAck high exactly one cycle; IRQ held afterwards -> no second entry while IE=0.
- Masking and boundaries:
  - Stimulus: IRQ=1 at step 2 with IE=1 -> required: ignored until the terminal step.
  - Stimulus: PCW at PC=16'hFFFF -> required: PC=16'h0000.
  - Stimulus: 16 steps without CounterRST -> required: Counter wraps 4'hF->0.
- Flags: wFlags with ALUFlags=5'b10101 -> Flags=5'b10101 next cycle; holds with wFlags=0 while ALUFlags changes.
